// File: rtl/pool_sign.sv
// pool_sign: 2x2 stride-2 max pooling followed by signed binarization.
// Consumes the raster-ordered signed convolution stream from conv and emits
// one pooled value per 2x2 block, in raster order of the pooled map, plus a
// 1-bit activation (pooled >= threshold).
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   start      one-cycle pulse, arms (or restarts) a frame
//   state      layer select sampled on start (0: W0 x W0, 1: W1 x W1)
//   threshold  signed binarization threshold sampled on start
//   din        signed conv result
//   ivalid     din valid
//   pool_out   signed pooled maximum (holds until next output)
//   dout       1 iff pool_out >= threshold (signed, inclusive)
//   ovalid     one-cycle pulse per pooled output
//   done       pulses together with the last output of a frame
//   busy       frame in progress
module pool_sign #(
  parameter int DW = 16,
  parameter int W0 = 24,
  parameter int W1 = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 state,
  input  logic signed [DW-1:0] threshold,
  input  logic signed [DW-1:0] din,
  input  logic                 ivalid,
  output logic signed [DW-1:0] pool_out,
  output logic                 dout,
  output logic                 ovalid,
  output logic                 done,
  output logic                 busy
);

  localparam int CW = $clog2(W0);
  localparam int LN = W0 / 2;
  localparam int LW = $clog2(LN);

  logic                 r_mode;
  logic signed [DW-1:0] r_thr;
  logic [CW-1:0]        r_col;
  logic [CW-1:0]        r_row;
  logic signed [DW-1:0] r_hold;
  logic signed [DW-1:0] r_lbuf [LN];

  logic                 w_accept;
  logic [CW-1:0]        w_wmax;
  logic                 w_col_last;
  logic                 w_row_last;
  logic [LW-1:0]        w_lidx;
  logic signed [DW-1:0] w_pair;
  logic signed [DW-1:0] w_pool;

  // A beat in the same cycle as start belongs to no frame and is dropped.
  assign w_accept   = ivalid & busy & ~start;
  assign w_wmax     = r_mode ? CW'(W1 - 1) : CW'(W0 - 1);
  assign w_col_last = (r_col == w_wmax);
  assign w_row_last = (r_row == w_wmax);
  assign w_lidx     = LW'(r_col >> 1);

  // Horizontal max of the held even-column sample and the odd-column beat,
  // then vertical max against the pair stored on the previous (even) row.
  assign w_pair = (din > r_hold) ? din : r_hold;
  assign w_pool = (r_lbuf[w_lidx] > w_pair) ? r_lbuf[w_lidx] : w_pair;

  // Line buffer of horizontal pair maxima; written on even rows and read on
  // the following odd row, so it never needs a reset.
  always_ff @(posedge clk) begin
    if (w_accept && r_col[0] && !r_row[0]) begin
      r_lbuf[w_lidx] <= w_pair;
    end
  end

  // Frame control, counters, even-column hold and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mode   <= 1'b0;
      r_thr    <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_hold   <= '0;
      pool_out <= '0;
      dout     <= 1'b0;
      ovalid   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      ovalid <= 1'b0;
      done   <= 1'b0;
      if (start) begin
        // Restarting while busy abandons the old frame silently.
        r_mode <= state;
        r_thr  <= threshold;
        r_col  <= '0;
        r_row  <= '0;
        busy   <= 1'b1;
      end else if (w_accept) begin
        if (!r_col[0]) begin
          r_hold <= din;
        end
        if (r_col[0] && r_row[0]) begin
          pool_out <= w_pool;
          dout     <= (w_pool >= r_thr);
          ovalid   <= 1'b1;
        end
        if (w_col_last) begin
          r_col <= '0;
          if (w_row_last) begin
            // Last beat of the frame: its output carries done.
            r_row <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            r_row <= r_row + CW'(1);
          end
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pool_sign.sv
module tb_pool_sign;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               start = 1'b0;
  logic               state = 1'b0;
  logic signed [15:0] threshold = 16'sd0;
  logic signed [15:0] din = 16'sd0;
  logic               ivalid = 1'b0;
  logic signed [15:0] pool_out;
  logic               dout;
  logic               ovalid;
  logic               done;
  logic               busy;

  pool_sign #(.DW(16), .W0(24), .W1(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .state(state),
    .threshold(threshold), .din(din), .ivalid(ivalid),
    .pool_out(pool_out), .dout(dout), .ovalid(ovalid),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pool;
    bit d;
    bit dn;
  } exp_t;

  exp_t exp_q[$];
  int   img[0:575];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: pooled (r,c) is the max of the 2x2 block of img; it appears only
  // if the block's last raster beat (index < n) was delivered.
  task automatic build(input int w, input int thr, input int n, input bit full);
    for (int r = 0; r < w / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        int a, b, e, f, m;
        exp_t x;
        a = img[(2*r)*w + 2*c];
        b = img[(2*r)*w + 2*c + 1];
        e = img[(2*r+1)*w + 2*c];
        f = img[(2*r+1)*w + 2*c + 1];
        m = a;
        if (b > m) m = b;
        if (e > m) m = e;
        if (f > m) m = f;
        if ((2*r+1)*w + 2*c + 1 < n) begin
          x.pool = m;
          x.d    = (m >= thr);
          x.dn   = full && (r == w/2 - 1) && (c == w/2 - 1);
          exp_q.push_back(x);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame; optionally present a beat in the start cycle (must be ignored).
  task automatic run(input int mode, input int thr, input int n, input int gap, input bit start_beat);
    start     = 1'b1;
    state     = mode[0];
    threshold = 16'(thr);
    ivalid    = start_beat;
    din       = 16'sd1111;
    tick();
    start  = 1'b0;
    ivalid = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      din    = 16'(img[i]);
      ivalid = 1'b1;
      tick();
      ivalid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic drain(input string nm);
    repeat (6) tick();
    chk(nm, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Compare process: every output pulse must match the model head.
  always @(negedge clk) begin
    if (rstn) begin
      if (ovalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ovalid_pool", pool_out, 99999);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pool_out", pool_out, e.pool);
          chk("dout", dout, e.d);
          chk("done", done, e.dn);
          if (done) chk("busy_at_done", busy, 0);
        end
      end else begin
        chk("done_idle", done, 0);
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_pool_out", pool_out, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovalid", ovalid, 0);
    chk("rst_busy", busy, 0);
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // Mode 0 ramp
    for (int i = 0; i < 576; i++) img[i] = i;
    build(24, 0, 576, 1'b1);
    chk("model_ramp_first", exp_q[0].pool, 25);
    chk("model_ramp_last", exp_q[143].pool, 575);
    chk("model_ramp_last_done", exp_q[143].dn, 1);
    run(0, 0, 576, 0, 1'b0);
    drain("ramp0_count");
    chk("ramp0_hold", pool_out, 575);
    chk("ramp0_busy_end", busy, 0);

    // Mode 0 negated ramp
    for (int i = 0; i < 576; i++) img[i] = -i;
    build(24, 0, 576, 1'b1);
    chk("model_neg_first", exp_q[0].pool, 0);
    chk("model_neg_first_d", exp_q[0].d, 1);
    chk("model_neg_second", exp_q[1].pool, -2);
    run(0, 0, 576, 0, 1'b0);
    drain("neg_count");
    chk("neg_hold", pool_out, -550);

    // Beats while idle are dropped
    for (int i = 0; i < 3; i++) begin
      din = 16'sd1234;
      ivalid = 1'b1;
      tick();
    end
    ivalid = 1'b0;
    repeat (3) tick();
    chk("idle_beats_hold", pool_out, -550);

    // Mode 1 with gaps, beat during start ignored
    for (int i = 0; i < 64; i++) img[i] = i;
    build(8, 5, 64, 1'b1);
    chk("model_m1_first", exp_q[0].pool, 9);
    chk("model_m1_row1", exp_q[4].pool, 25);
    chk("model_m1_last", exp_q[15].pool, 63);
    run(1, 5, 64, 1, 1'b1);
    drain("m1_count");
    chk("m1_hold", pool_out, 63);

    // Signed extremes, threshold 100
    for (int i = 0; i < 64; i++) img[i] = 0;
    img[0] = -32768; img[1] = 99;     img[8] = -5;     img[9] = 100;
    img[2] = 99;     img[3] = -32768; img[10] = 32767; img[11] = -1;
    img[4] = -1;     img[5] = -2;     img[12] = -3;    img[13] = 99;
    build(8, 100, 64, 1'b1);
    chk("model_ext0", exp_q[0].pool, 100);
    chk("model_ext0_d", exp_q[0].d, 1);
    chk("model_ext1", exp_q[1].pool, 32767);
    chk("model_ext2", exp_q[2].pool, 99);
    chk("model_ext2_d", exp_q[2].d, 0);
    run(1, 100, 64, 0, 1'b0);
    drain("ext_count");

    // Reset mid-frame after 300 beats
    for (int i = 0; i < 576; i++) img[i] = i;
    build(24, 0, 300, 1'b0);
    run(0, 0, 300, 0, 1'b0);
    repeat (4) tick();
    chk("abort_rst_count", exp_q.size(), 0);
    chk("abort_pre_rst_hold", pool_out, 287);
    rstn = 1'b0;
    #1;
    chk("abort_rst_pool_out", pool_out, 0);
    chk("abort_rst_busy", busy, 0);
    chk("abort_rst_ovalid", ovalid, 0);
    tick();
    rstn = 1'b1;
    tick();
    build(24, 0, 576, 1'b1);
    run(0, 0, 576, 0, 1'b0);
    drain("after_rst_count");
    chk("after_rst_hold", pool_out, 575);

    // Start reasserted after 100 beats
    build(24, 0, 100, 1'b0);
    run(0, 0, 100, 0, 1'b0);
    build(24, 0, 576, 1'b1);
    run(0, 0, 576, 0, 1'b1);
    drain("restart_count");
    chk("restart_hold", pool_out, 575);
    chk("restart_busy_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool_sign.md
# pool_sign

Downstream stage of `conv`. Consumes the raster-ordered signed convolution stream (`dout`/`ovalid`), applies 2x2 stride-2 max pooling, then binarizes each pooled value against a threshold. The result is the 1-bit activation map for the next BNN layer:
- layer 1 (`state`=0): 24x24 -> 12x12
- layer 2 (`state`=1): 8x8 -> 4x4

The pooled 16-bit value is also exported for debug and bench checking.

## Interface
Parameters:
- `DW`, 16, conv result width (signed)
- `W0`, 24, feature-map width/height when `state`=0
- `W1`, 8, feature-map width/height when `state`=1

Ports:
- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle pulse; arms a new frame
- `state`  in  1  layer select, sampled on `start` (0: W0, 1: W1)
- `threshold`  in  DW  signed binarization threshold, sampled on `start`
- `din`  in  DW  signed conv result (from `conv.dout`)
- `ivalid`  in  1  `din` valid (from `conv.ovalid`)
- `pool_out`  out  DW  signed pooled maximum
- `dout`  out  1  binary activation: 1 iff `pool_out` >= threshold (signed)
- `ovalid`  out  1  `pool_out`/`dout` valid, one-cycle pulse per output
- `done`  out  1  pulses with the last output of a frame
- `busy`  out  1  frame in progress

## Operation
- Registers:
  - `mode`, `thr`: latched at `start`.
  - `col` and `row`: counters, 0..W-1, where W = `mode` ? W1 : W0.
  - `hold`: DW register holding the even-column sample.
  - `lbuf`: line buffer, W0/2 entries x DW.
- `start` pulse behaviour:
  - latches `mode`/`thr`, clears `col`/`row`, sets `busy`=1.
  - If asserted while `busy`, the current frame is abandoned and restarts; no `done` is issued for the abandoned frame.
- An input beat is accepted iff `ivalid` && `busy` && !`start`. Any beat with `busy`=0, or in the same cycle as `start`, is dropped.
- Per accepted beat:
  - even `col`: `hold` <= `din`.
  - odd `col`: pair = max(`hold`, `din`), signed.
    - even `row`: `lbuf[col>>1]` <= pair.
    - odd `row`: m = max(`lbuf[col>>1]`, pair); next cycle `pool_out` <= m, `dout` <= (m >= `thr`), `ovalid` <= 1.
- Counter update:
  - `col` increments on every accepted beat.
  - At W-1, `col` wraps to 0 and `row` increments.
- On the beat at `row`=W-1, `col`=W-1:
  - next cycle: `done`=1 together with `ovalid`=1.
  - `busy` clears on the same edge; counters return to 0.
- Outputs per frame: (W/2)^2, i.e. 144 (mode 0) or 16 (mode 1), in raster order of the pooled map.
- `lbuf` needs no reset: every entry is written on an even row before it is read on the following odd row.
- All compares are signed two's-complement on DW bits. Ties pass either operand (values are equal). The threshold compare is inclusive (>=).
- Upstream `conv.done` is not used; frame end is derived from the counters.

## Timing
- Reset (`rstn`=0, asynchronous, effective immediately):
  - `pool_out`=0, `dout`=0, `ovalid`=0, `done`=0, `busy`=0.
  - `col`=`row`=0, `hold`=0, `mode`=0, `thr`=0.
- Reset mid-frame aborts the frame with no further outputs. A fresh `start` is required afterwards.
- Latency: `ovalid` rises exactly 1 cycle after the accepted beat at odd row / odd col. `pool_out`/`dout` hold their value until the next output.
- `ovalid` and `done` are single-cycle pulses.
- `ivalid` may have arbitrary gaps; no state advances on idle cycles.
- Throughput is 1 beat/cycle with no backpressure (no ready signal).
- Earliest accepted beat is the cycle after `start`.

## Test plan
- Mode 0, `thr`=0, `din`=raster index 0..575 back-to-back:
  - 144 outputs; output k=(r,c) has `pool_out`=(2r+1)*24+2c+1 and `dout`=1.
  - `done` coincides only with the 144th output (value 575); `busy` falls on the same edge.
- Mode 0, `thr`=0, `din`=-(raster index):
  - output (r,c) has `pool_out`=-(48r+2c).
  - First output is 0 with `dout`=1; all others have `dout`=0.
- Mode 1, `thr`=5, 8x8 ramp 0..63 with `ivalid` toggled every other cycle:
  - 16 outputs with `pool_out`=(2r+1)*8+2c+1, i.e. 9, 11, 13, 15, 25, ... 63; all `dout`=1.
  - Gaps do not shift the results; `done` occurs with value 63.
- Signed extremes and threshold, `thr`=100:
  - 2x2 block {-32768, 99, -5, 100} -> `pool_out`=100, `dout`=1.
  - block {99, -32768, 32767, -1} -> 32767, `dout`=1.
  - block {-1, -2, -3, 99} -> 99, `dout`=0.
- Abort cases:
  - `rstn` pulsed low after 300 beats of a mode-0 frame -> all outputs 0 asynchronously. A new `start` plus a full ramp reproduces scenario 1 exactly.
  - `start` reasserted after 100 beats -> no `done` for the first frame; the second frame's 144 outputs are correct.
- Beats with `busy`=0, and a beat in the same cycle as `start`, are ignored: output values and counts are unchanged.
